// File: rtl/sram_ctrl.sv
// sram_ctrl: request/ready front end that sequences setup/pulse/hold strobes for the async 256x8 SRAM
module sram_ctrl #(
  parameter int SETUP = 1,
  parameter int PULSE = 2,
  parameter int HOLD  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_i,
  input  logic       we_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       ready_o,
  output logic       wdone_o,
  output logic       rvalid_o,
  output logic [7:0] rdata_o,
  output logic       sram_cs_o,
  output logic       sram_wr_o,
  output logic       sram_rd_o,
  output logic [7:0] sram_addr_o,
  output logic [7:0] sram_din_o,
  input  logic [7:0] sram_dout_i
);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_PULSE, S_HOLD} state_t;
  state_t     state_q;
  logic [3:0] cnt_q;
  logic       we_q, ready_q, wdone_q, rvalid_q, cs_q, wr_q, rd_q;
  logic [7:0] rdata_q, addr_q, din_q;
  // Phase sequencer; every pin is a register so reset can only drive strobes to their idle levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      ready_q  <= 1'b1;
      wdone_q  <= 1'b0;
      rvalid_q <= 1'b0;
      cs_q     <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b1;
      rdata_q  <= 8'h00;
      addr_q   <= 8'h00;
      din_q    <= 8'h00;
    end else begin
      wdone_q  <= 1'b0;
      rvalid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (req_i) begin
          we_q    <= we_i;
          addr_q  <= addr_i;
          din_q   <= wdata_i;
          cnt_q   <= 4'(SETUP - 1);
          state_q <= S_SETUP;
          ready_q <= 1'b0;
          cs_q    <= 1'b1;
        end
        S_SETUP: if (cnt_q == 4'd0) begin
          cnt_q   <= 4'(PULSE - 1);
          state_q <= S_PULSE;
          wr_q    <= we_q;
          rd_q    <= we_q;
        end else cnt_q <= cnt_q - 4'd1;
        S_PULSE: if (cnt_q == 4'd0) begin
          cnt_q   <= 4'(HOLD - 1);
          state_q <= S_HOLD;
          wr_q    <= 1'b0;
          rd_q    <= 1'b1;
          if (!we_q) rdata_q <= sram_dout_i;
        end else cnt_q <= cnt_q - 4'd1;
        default: if (cnt_q == 4'd0) begin
          state_q  <= S_IDLE;
          cs_q     <= 1'b0;
          ready_q  <= 1'b1;
          wdone_q  <= we_q;
          rvalid_q <= !we_q;
        end else cnt_q <= cnt_q - 4'd1;
      endcase
    end
  end
  assign ready_o     = ready_q;
  assign wdone_o     = wdone_q;
  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign sram_cs_o   = cs_q;
  assign sram_wr_o   = wr_q;
  assign sram_rd_o   = rd_q;
  assign sram_addr_o = addr_q;
  assign sram_din_o  = din_q;
endmodule
